// File: rtl/prbs9_checker_pkg.sv
// Shared PRBS9 definitions for the Tx generator and the Rx checker.
// Polynomial x^9+x^5+1, taps [8]^[4], plus the checker state encodings.
package prbs9_checker_pkg;

    localparam int NB_REG = 9;
    localparam int TAP_A  = 8;
    localparam int TAP_B  = 4;

    localparam logic [NB_REG-1:0] SEED = 9'b110101010;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/prbs9_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// It holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int NB = 32
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [NB-1:0] o_cnt
);

    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prbs9_checker.sv
// Rx PRBS9 checker: self-syncs on received bits, confirms, then
// flywheels its LFSR and counts checked bits and errors while locked.
module prbs9_checker
    import prbs9_checker_pkg::*;
#(
    parameter int NB_CNT   = 32,
    parameter int SYNC_LEN = 16,
    parameter int WIN_LEN  = 128,
    parameter int LOS_THR  = 8
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_EnbRx,
    input  logic [1:0]        i_enable_sample,
    input  logic              i_rx_bit,
    input  logic              i_clr_cnt,
    output logic              o_lock,
    output logic              o_err,
    output logic [NB_CNT-1:0] o_bit_count,
    output logic [NB_CNT-1:0] o_err_count
);

    localparam int FILL_W = $clog2(NB_REG + 1);
    localparam int SYNC_W = $clog2(SYNC_LEN + 1);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int WERR_W = $clog2(LOS_THR + 2);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NB_REG - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0] WERR_MAX  = WERR_W'(LOS_THR);

    state_t              state, state_nxt;
    logic [NB_REG-1:0]   h, h_nxt;
    logic [FILL_W-1:0]   fill_cnt, fill_nxt;
    logic [SYNC_W-1:0]   sync_cnt, sync_nxt;
    logic [WIN_W-1:0]    win_cnt, win_nxt;
    logic [WERR_W-1:0]   win_err, werr_nxt;
    logic                err_nxt;
    logic                valid;
    logic                pred;
    logic                mis;
    logic                inc_bit;
    logic                inc_err;

    assign valid = i_EnbRx && (i_enable_sample == 2'b11);
    assign pred  = h[TAP_A] ^ h[TAP_B];
    assign mis   = i_rx_bit ^ pred;

    always_comb begin
        state_nxt = state;
        h_nxt     = h;
        fill_nxt  = fill_cnt;
        sync_nxt  = sync_cnt;
        win_nxt   = win_cnt;
        werr_nxt  = win_err;
        err_nxt   = 1'b0;
        if (valid) begin
            unique case (state)
                ST_HUNT: begin
                    h_nxt    = {h[NB_REG-2:0], i_rx_bit};
                    fill_nxt = fill_cnt + 1'b1;
                    if (fill_cnt == FILL_LAST) begin
                        state_nxt = ST_CHECK;
                        sync_nxt  = '0;
                    end
                end
                ST_CHECK: begin
                    h_nxt = {h[NB_REG-2:0], i_rx_bit};
                    if (mis) begin
                        state_nxt = ST_HUNT;
                        fill_nxt  = '0;
                    end else begin
                        sync_nxt = sync_cnt + 1'b1;
                        if (sync_cnt == SYNC_LAST) begin
                            state_nxt = ST_LOCKED;
                            win_nxt   = '0;
                            werr_nxt  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // flywheel: the prediction, not the rx bit, feeds the LFSR
                    h_nxt    = {h[NB_REG-2:0], pred};
                    err_nxt  = mis;
                    win_nxt  = win_cnt + 1'b1;
                    werr_nxt = win_err + WERR_W'(mis);
                    if (werr_nxt > WERR_MAX) begin
                        state_nxt = ST_HUNT;
                        fill_nxt  = '0;
                    end
                    if (win_cnt == WIN_LAST) begin
                        win_nxt  = '0;
                        werr_nxt = '0;
                    end
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state    <= ST_HUNT;
            h        <= '0;
            fill_cnt <= '0;
            sync_cnt <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            h        <= h_nxt;
            fill_cnt <= fill_nxt;
            sync_cnt <= sync_nxt;
            win_cnt  <= win_nxt;
            win_err  <= werr_nxt;
            o_err    <= err_nxt;
        end
    end

    assign o_lock  = (state == ST_LOCKED);
    assign inc_bit = valid && (state == ST_LOCKED);
    assign inc_err = inc_bit && mis;

    sat_counter #(.NB(NB_CNT)) u_bit_cnt (
        .clk   (clk),
        .i_rst (i_rst),
        .i_clr (i_clr_cnt),
        .i_inc (inc_bit),
        .o_cnt (o_bit_count)
    );

    sat_counter #(.NB(NB_CNT)) u_err_cnt (
        .clk   (clk),
        .i_rst (i_rst),
        .i_clr (i_clr_cnt),
        .i_inc (inc_err),
        .o_cnt (o_err_count)
    );

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: a 32-bit and a 4-bit counter
// instance share one PRBS9 stimulus stream.
module tb_prbs9_checker;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_EnbRx = 1'b1;
    logic [1:0]  i_enable_sample = 2'b00;
    logic        i_rx_bit = 1'b0;
    logic        i_clr_cnt = 1'b0;

    logic        o_lock, o_err;
    logic [31:0] o_bit_count, o_err_count;
    logic        l4, e4;
    logic [3:0]  b4, c4;

    always #5 clk = ~clk;

    prbs9_checker dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_EnbRx         (i_EnbRx),
        .i_enable_sample (i_enable_sample),
        .i_rx_bit        (i_rx_bit),
        .i_clr_cnt       (i_clr_cnt),
        .o_lock          (o_lock),
        .o_err           (o_err),
        .o_bit_count     (o_bit_count),
        .o_err_count     (o_err_count)
    );

    prbs9_checker #(.NB_CNT(4)) dut4 (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_EnbRx         (i_EnbRx),
        .i_enable_sample (i_enable_sample),
        .i_rx_bit        (i_rx_bit),
        .i_clr_cnt       (i_clr_cnt),
        .o_lock          (l4),
        .o_err           (e4),
        .o_bit_count     (b4),
        .o_err_count     (c4)
    );

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int stuck  = 0;
    logic [8:0] tx = 9'b110101010;

    typedef struct {
        string name;
        int    n;
        int    nflip;
        bit    lock;
        int    bits;
        int    errs;
        int    pulses;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic gen();
        logic fb;
        fb = tx[8] ^ tx[4];
        tx = {tx[7:0], fb};
        return fb;
    endfunction

    // one valid sample, then three idle clocks
    task automatic samp(input bit flip, input bit clr);
        @(negedge clk);
        i_rx_bit        = gen() ^ flip;
        i_enable_sample = 2'b11;
        i_clr_cnt       = clr;
        @(negedge clk);
        if (o_err) pulses++;
        i_enable_sample = 2'b00;
        i_clr_cnt       = 1'b0;
        @(negedge clk);
        if (o_err) stuck++;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{"hunt24",   24,   0, 1'b0,    0,  0, 0};
        tbl[1] = '{"lock25",    1,   0, 1'b1,    0,  0, 0};
        tbl[2] = '{"run1000", 1000,  0, 1'b1, 1000,  0, 0};
        tbl[3] = '{"flip1",    10,   1, 1'b1, 1010,  1, 1};
        tbl[4] = '{"align",    14,   0, 1'b1, 1024,  1, 0};
        tbl[5] = '{"err8",      8,   8, 1'b1, 1032,  9, 8};
        tbl[6] = '{"err9",      1,   1, 1'b0, 1033, 10, 1};

        repeat (3) @(negedge clk);
        chk("rst_lock", o_lock, 0);
        chk("rst_err", o_err, 0);
        chk("rst_bits", o_bit_count, 0);
        chk("rst_errs", o_err_count, 0);
        i_rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            pulses = 0;
            for (int k = 0; k < tbl[v].n; k++) samp(k < tbl[v].nflip, 1'b0);
            chk({tbl[v].name, "_lock"}, o_lock, tbl[v].lock);
            chk({tbl[v].name, "_bits"}, o_bit_count, tbl[v].bits);
            chk({tbl[v].name, "_errs"}, o_err_count, tbl[v].errs);
            chk({tbl[v].name, "_pulses"}, pulses, tbl[v].pulses);
        end

        for (int k = 0; k < 24; k++) samp(1'b0, 1'b0);
        chk("relock24_lock", o_lock, 0);
        samp(1'b0, 1'b0);
        chk("relock25_lock", o_lock, 1);
        chk("relock_bits", o_bit_count, 1033);
        chk("relock_errs", o_err_count, 10);

        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            i_EnbRx         = (k >= 50);
            i_enable_sample = (k < 50) ? 2'b11 : 2'b01;
            i_rx_bit        = 1'($urandom);
            @(negedge clk);
        end
        i_EnbRx = 1'b1;
        i_enable_sample = 2'b00;
        chk("freeze_lock", o_lock, 1);
        chk("freeze_bits", o_bit_count, 1033);
        chk("freeze_errs", o_err_count, 10);
        pulses = 0;
        samp(1'b0, 1'b0);
        chk("resume_bits", o_bit_count, 1034);
        chk("resume_errs", o_err_count, 10);
        chk("resume_pulses", pulses, 0);

        @(negedge clk);
        i_rst           = 1'b1;
        i_rx_bit        = gen() ^ 1'b1;
        i_enable_sample = 2'b11;
        @(negedge clk);
        chk("midrst_lock", o_lock, 0);
        chk("midrst_err", o_err, 0);
        chk("midrst_bits", o_bit_count, 0);
        chk("midrst_errs", o_err_count, 0);
        i_rst = 1'b0;
        i_enable_sample = 2'b00;

        for (int k = 0; k < 19; k++) samp(1'b0, 1'b0);
        samp(1'b1, 1'b0);
        for (int k = 0; k < 24; k++) samp(1'b0, 1'b0);
        chk("chkerr_lock24", o_lock, 0);
        samp(1'b0, 1'b0);
        chk("chkerr_lock25", o_lock, 1);
        chk("chkerr_bits", o_bit_count, 0);

        for (int k = 0; k < 20; k++) samp(1'b0, 1'b0);
        chk("sat_bits32", o_bit_count, 20);
        chk("sat_bits4", b4, 15);
        chk("sat_errs4", c4, 0);
        pulses = 0;
        samp(1'b1, 1'b1);
        chk("clr_pulse", pulses, 1);
        chk("clr_bits", o_bit_count, 0);
        chk("clr_errs", o_err_count, 0);
        chk("clr_bits4", b4, 0);
        chk("clr_lock", o_lock, 1);
        samp(1'b0, 1'b0);
        chk("postclr_bits", o_bit_count, 1);
        chk("postclr_errs", o_err_count, 0);

        chk("err_one_cycle", stuck, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
